// File: rtl/fifo_pkg.sv
`default_nettype none
// =====================================================================
// fifo_pkg : sizing helper and status bundle shared by the FIFO blocks
// Rev 1.0
// =====================================================================
package fifo_pkg;

  // Address width never drops below one bit, even for tiny depths.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/wrap_ptr.sv
`default_nettype none
// =====================================================================
// wrap_ptr : address pointer that wraps DEPTH-1 -> 0 at any depth
// Rev 1.0
// =====================================================================
module wrap_ptr
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  logic [AW-1:0] r_ptr;

  // Explicit compare so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_status_ctrl.sv
`default_nettype none
// =====================================================================
// fifo_status_ctrl : FIFO pointers, occupancy count and status flags
// Rev 1.0
// =====================================================================
module fifo_status_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int AF_LEVEL = DEPTH - 4,
  parameter  int AE_LEVEL = 4,
  localparam int AW       = clog2_min1(DEPTH),
  localparam int CW       = clog2_min1(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr_err,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  if (DEPTH < 2 || DEPTH > 1024 || AE_LEVEL < 0 ||
      !(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_params
    $fatal(1, "fifo_status_ctrl: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_AE    = CW'(AE_LEVEL);

  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_wr_en;
  logic          w_rd_en;
  fifo_status_t  w_status;

  // Flags decode only the registered count: no input-to-flag path.
  assign w_status.full         = (r_count == c_DEPTH);
  assign w_status.empty        = (r_count == '0);
  assign w_status.almost_full  = (r_count >= c_AF);
  assign w_status.almost_empty = (r_count <= c_AE);
  assign w_status.overflow     = r_overflow;
  assign w_status.underflow    = r_underflow;

  assign w_wr_en = wr & ~w_status.full;
  assign w_rd_en = rd & ~w_status.empty;

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_wr_en),
    .ptr (wr_addr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_rd_en),
    .ptr (rd_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wr & w_status.full)  | (r_overflow  & ~clr_err);
      r_underflow <= (rd & w_status.empty) | (r_underflow & ~clr_err);
    end
  end

  assign wr_en        = w_wr_en;
  assign rd_en        = w_rd_en;
  assign count        = r_count;
  assign full         = w_status.full;
  assign empty        = w_status.empty;
  assign almost_full  = w_status.almost_full;
  assign almost_empty = w_status.almost_empty;
  assign overflow     = w_status.overflow;
  assign underflow    = w_status.underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_status_ctrl.sv
`default_nettype none
// =====================================================================
// tb_fifo_status_ctrl : scoreboard bench, DEPTH=32 and DEPTH=24 instances
// Rev 1.0
// =====================================================================
module tb_fifo_status_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, wr, rd, clr_err, sel;

  logic       a_wr, a_rd, a_clr, a_wen, a_ren, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_wa, a_ra;
  logic [5:0] a_cnt;
  logic       b_wr, b_rd, b_clr, b_wen, b_ren, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] b_wa, b_ra;
  logic [4:0] b_cnt;

  assign a_wr  = wr & ~sel;
  assign a_rd  = rd & ~sel;
  assign a_clr = clr_err & ~sel;
  assign b_wr  = wr & sel;
  assign b_rd  = rd & sel;
  assign b_clr = clr_err & sel;

  fifo_status_ctrl #(.DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4)) u_dut32 (
    .clk(clk), .rst(rst), .wr(a_wr), .rd(a_rd), .clr_err(a_clr),
    .wr_en(a_wen), .rd_en(a_ren), .wr_addr(a_wa), .rd_addr(a_ra), .count(a_cnt),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_status_ctrl #(.DEPTH(24), .AF_LEVEL(20), .AE_LEVEL(2)) u_dut24 (
    .clk(clk), .rst(rst), .wr(b_wr), .rd(b_rd), .clr_err(b_clr),
    .wr_en(b_wen), .rd_en(b_ren), .wr_addr(b_wa), .rd_addr(b_ra), .count(b_cnt),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_unf)
  );

  // Observed vector: {wen, ren, wa[4:0], ra[4:0], cnt[5:0], full, empty, af, ae, ovf, unf}
  logic [23:0] w_obs;
  assign w_obs = sel ? {b_wen, b_ren, b_wa, b_ra, {1'b0, b_cnt}, b_full, b_empty, b_af, b_ae, b_ovf, b_unf}
                     : {a_wen, a_ren, a_wa, a_ra, a_cnt, a_full, a_empty, a_af, a_ae, a_ovf, a_unf};

  typedef struct {
    logic [23:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t r_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference occupancy model (modulo arithmetic on plain integers)
  int m_depth, m_af, m_ae, m_cnt, m_wa, m_ra;
  bit m_ovf, m_unf;

  function automatic logic [23:0] pack_exp(input bit wen, input bit ren);
    return {wen, ren, 5'(m_wa), 5'(m_ra), 6'(m_cnt),
            (m_cnt == m_depth), (m_cnt == 0), (m_cnt >= m_af), (m_cnt <= m_ae), m_ovf, m_unf};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic push_exp(input bit wen, input bit ren, input string tag);
    exp_t e;
    e.v   = pack_exp(wen, ren);
    e.tag = tag;
    q.push_back(e);
  endtask

  // Called at posedge+1; applies one cycle of stimulus and returns at the next posedge+1.
  task automatic step(input bit w, input bit r, input bit c, input string tag);
    bit wen, ren;
    wr = w; rd = r; clr_err = c;
    wen = w && (m_cnt != m_depth);
    ren = r && (m_cnt != 0);
    push_exp(wen, ren, tag);
    m_ovf = (w && m_cnt == m_depth) || (m_ovf && !c);
    m_unf = (r && m_cnt == 0) || (m_unf && !c);
    m_cnt = m_cnt + int'(wen) - int'(ren);
    if (wen) m_wa = (m_wa + 1) % m_depth;
    if (ren) m_ra = (m_ra + 1) % m_depth;
    @(posedge clk);
    #1;
  endtask

  task automatic repeat_step(input int n, input bit w, input bit r, input string tag);
    for (int i = 0; i < n; i++) step(w, r, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    model_reset();
    push_exp(1'b0, 1'b0, tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reset pulsed between edges; outputs are checked before the next rising edge.
  task automatic async_pulse(input string tag);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    push_exp(1'b0, 1'b0, tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      r_e = q.pop_front();
      checks++;
      if (w_obs !== r_e.v) begin
        failures++;
        $display("FAIL %s @%0t: got wen=%b ren=%b wa=%0d ra=%0d cnt=%0d f/e/af/ae/ov/un=%b required wen=%b ren=%b wa=%0d ra=%0d cnt=%0d f/e/af/ae/ov/un=%b",
                 r_e.tag, $time, w_obs[23], w_obs[22], w_obs[21:17], w_obs[16:12], w_obs[11:6], w_obs[5:0],
                 r_e.v[23], r_e.v[22], r_e.v[21:17], r_e.v[16:12], r_e.v[11:6], r_e.v[5:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; sel = 1'b0;
    m_depth = 32; m_af = 28; m_ae = 4;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset32");

    // Fill, overflow on the 33rd write
    repeat_step(32, 1'b1, 1'b0, "fill32");
    step(1'b1, 1'b0, 1'b0, "wr_when_full");
    step(1'b0, 1'b0, 1'b0, "overflow_set");

    // Drain, underflow, then clear both errors
    repeat_step(32, 1'b0, 1'b1, "drain32");
    step(1'b0, 1'b1, 1'b0, "rd_when_empty");
    step(1'b0, 1'b0, 1'b1, "clr_err");
    step(1'b0, 1'b0, 1'b0, "errors_cleared");

    // Steady state at count=10 with simultaneous traffic
    repeat_step(10, 1'b1, 1'b0, "fill_to_10");
    repeat_step(50, 1'b1, 1'b1, "rw_at_10");

    // Boundary simultaneity at full and at empty
    repeat_step(22, 1'b1, 1'b0, "fill_to_32");
    step(1'b1, 1'b1, 1'b0, "rw_at_full");
    step(1'b0, 1'b0, 1'b0, "after_rw_full");
    step(1'b0, 1'b0, 1'b1, "clr_ovf");
    repeat_step(31, 1'b0, 1'b1, "drain_to_0");
    step(1'b1, 1'b1, 1'b0, "rw_at_empty");
    step(1'b0, 1'b0, 1'b0, "after_rw_empty");
    step(1'b0, 1'b0, 1'b1, "clr_unf");

    // Async reset mid-operation at count=17
    repeat_step(16, 1'b1, 1'b0, "fill_to_17");
    async_pulse("async_rst");
    step(1'b1, 1'b0, 1'b0, "first_wr_after_rst");
    step(1'b0, 1'b0, 1'b0, "idle_after_rst");

    // Non-power-of-two depth
    sel = 1'b1;
    m_depth = 24; m_af = 20; m_ae = 2;
    do_reset("reset24");
    repeat_step(24, 1'b1, 1'b0, "fill24");
    step(1'b1, 1'b0, 1'b0, "wr_full24");
    step(1'b0, 1'b0, 1'b1, "clr24");
    repeat_step(24, 1'b0, 1'b1, "drain24");
    step(1'b0, 1'b1, 1'b0, "rd_empty24");
    step(1'b0, 1'b0, 1'b1, "clr24b");
    repeat_step(18, 1'b1, 1'b0, "prefill24");
    for (int i = 0; i < 100; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 15) == 0), "rand24");
    end
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
